// File: rtl/rho_cim_pkg.sv
// Shared types and helpers for the CIM datapath layers.
package rho_cim_pkg;

  localparam int POOL_MAX_DW = 32;

  // Wide signed container; narrower samples are sign-extended into it before comparison.
  typedef logic signed [POOL_MAX_DW-1:0] pool_sample_t;

  function automatic pool_sample_t signed_max(input pool_sample_t a, input pool_sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one row of horizontal pair maxima per channel.
// One synchronous write port, one combinational read port.
module pool_line_buf #(
  parameter int DEPTH  = 140,
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  // Contents are not reset: every entry is written on an even row before an odd row reads it.
  logic [WIDTH-1:0] r_mem [DEPTH-1:0];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_layer.sv
// 2x2 stride-2 per-channel max pooling over a channel-interleaved raster stream.
// Define POOL_RELU_EN to clamp negative pooled results to zero.
module pool_layer
  import rho_cim_pkg::*;
#(
  parameter int channels      = 10,
  parameter int img_width     = 28,
  parameter int datatype_size = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [datatype_size-1:0] i_data,
  output logic                     o_busy,
  input  logic                     i_next_busy,
  output logic                     o_ibuf_we      [channels-1:0],
  output logic [datatype_size-1:0] o_ibuf_wr_data [channels-1:0],
  output logic                     o_frame_done
);

  localparam int OUT_W    = img_width / 2;
  localparam int LB_DEPTH = OUT_W * channels;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int CH_W     = (channels > 1) ? $clog2(channels) : 1;
  localparam int POS_W    = $clog2(img_width);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(channels - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(img_width - 1);
  localparam bit               ODD_WIDTH = (img_width % 2) == 1;

  logic [CH_W-1:0]          r_ch;
  logic [POS_W-1:0]         r_col;
  logic [POS_W-1:0]         r_row;
  logic [datatype_size-1:0] r_hreg [channels-1:0];

  logic                     w_accept;
  logic                     w_discard;
  logic                     w_last;
  logic                     w_lb_we;
  logic [LB_AW-1:0]         w_lb_addr;
  logic [datatype_size-1:0] w_lb_rdata;
  logic [datatype_size-1:0] w_hreg_sel;
  logic [datatype_size-1:0] w_hmax_trunc;
  logic [datatype_size-1:0] w_result;
  pool_sample_t             w_hmax;
  pool_sample_t             w_vmax;

  function automatic pool_sample_t sext(input logic [datatype_size-1:0] v);
    return pool_sample_t'($signed(v));
  endfunction

  assign o_busy    = rst | i_next_busy;
  assign w_accept  = i_valid & ~o_busy;
  // An odd width leaves a trailing column and row that belong to no 2x2 window.
  assign w_discard = ODD_WIDTH && ((r_col == POS_LAST) || (r_row == POS_LAST));
  assign w_last    = (r_ch == CH_LAST) && (r_col == POS_LAST) && (r_row == POS_LAST);
  assign w_lb_we   = w_accept && !w_discard && r_col[0] && !r_row[0];
  assign w_lb_addr = LB_AW'(r_col >> 1) * LB_AW'(channels) + LB_AW'(r_ch);

  always_comb begin
    w_hreg_sel = '0;
    for (int c = 0; c < channels; c++) begin
      if (r_ch == CH_W'(c)) w_hreg_sel = r_hreg[c];
    end
  end

  assign w_hmax       = signed_max(sext(w_hreg_sel), sext(i_data));
  assign w_vmax       = signed_max(w_hmax, sext(w_lb_rdata));
  assign w_hmax_trunc = datatype_size'(w_hmax);
`ifdef POOL_RELU_EN
  assign w_result = (w_vmax < 0) ? '0 : datatype_size'(w_vmax);
`else
  assign w_result = datatype_size'(w_vmax);
`endif

  pool_line_buf #(
    .DEPTH  (LB_DEPTH),
    .WIDTH  (datatype_size),
    .ADDR_W (LB_AW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_hmax_trunc),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      o_frame_done <= 1'b0;
      for (int c = 0; c < channels; c++) begin
        r_hreg[c]         <= '0;
        o_ibuf_we[c]      <= 1'b0;
        o_ibuf_wr_data[c] <= '0;
      end
    end else begin
      o_frame_done <= w_accept && w_last;
      for (int c = 0; c < channels; c++) begin
        o_ibuf_we[c] <= 1'b0;
        if (w_accept && !w_discard && (r_ch == CH_W'(c))) begin
          if (!r_col[0]) begin
            r_hreg[c] <= i_data;
          end else if (r_row[0]) begin
            o_ibuf_we[c]      <= 1'b1;
            o_ibuf_wr_data[c] <= w_result;
          end
        end
      end
      // Channel wraps into column, column into row; row wraps straight into the next frame.
      if (w_accept) begin
        if (r_ch == CH_LAST) begin
          r_ch <= '0;
          if (r_col == POS_LAST) begin
            r_col <= '0;
            r_row <= (r_row == POS_LAST) ? '0 : r_row + POS_W'(1);
          end else begin
            r_col <= r_col + POS_W'(1);
          end
        end else begin
          r_ch <= r_ch + CH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
// Bench for pool_layer: a 1-channel 4x4 directed instance and a 2-channel 5x5 randomized
// instance checked against a window-based reference model. Honours POOL_RELU_EN.
module tb_pool_layer;

  localparam int BC     = 2;
  localparam int BW     = 5;
  localparam int BFRAME = BC * BW * BW;
`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aRst, aValid, aNextBusy, aBusy, aDone;
  logic [3:0] aData;
  logic       aWe     [0:0];
  logic [3:0] aWrData [0:0];

  logic       bRst, bValid, bNextBusy, bBusy, bDone;
  logic [3:0] bData;
  logic       bWe     [BC-1:0];
  logic [3:0] bWrData [BC-1:0];

  int total = 0;
  int bad   = 0;

  // Reference model state: the current frame as a plain image, and expected outputs.
  int   img [BW][BW][BC];
  int   k = 0;
  logic expWe   [BC];
  int   expData [BC];
  logic expDone;
  int   doneCount = 0;
  int   wrCount [BC];
  int   aExp [4];
  int   aIdx;

  pool_layer #(.channels(1), .img_width(4), .datatype_size(4)) dutA (
    .clk            (clk),
    .rst            (aRst),
    .i_valid        (aValid),
    .i_data         (aData),
    .o_busy         (aBusy),
    .i_next_busy    (aNextBusy),
    .o_ibuf_we      (aWe),
    .o_ibuf_wr_data (aWrData),
    .o_frame_done   (aDone)
  );

  pool_layer #(.channels(BC), .img_width(BW), .datatype_size(4)) dutB (
    .clk            (clk),
    .rst            (bRst),
    .i_valid        (bValid),
    .i_data         (bData),
    .o_busy         (bBusy),
    .i_next_busy    (bNextBusy),
    .o_ibuf_we      (bWe),
    .o_ibuf_wr_data (bWrData),
    .o_frame_done   (bDone)
  );

  function automatic int sx4(input logic [3:0] v);
    return int'($signed(v));
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the 2x2 window of the image accepted so far.
  task automatic modelStep(input logic r, input logic v, input logic nb, input logic [3:0] d);
    int c, pix, col, row, m;
    for (int i = 0; i < BC; i++) expWe[i] = 1'b0;
    expDone = 1'b0;
    if (r) begin
      k = 0;
      for (int i = 0; i < BC; i++) expData[i] = 0;
    end else if (v && !nb) begin
      c   = k % BC;
      pix = k / BC;
      col = pix % BW;
      row = pix / BW;
      img[row][col][c] = sx4(d);
      if ((row % 2 == 1) && (col % 2 == 1) && (row < 2 * (BW / 2)) && (col < 2 * (BW / 2))) begin
        m = img[row-1][col-1][c];
        if (img[row-1][col][c] > m) m = img[row-1][col][c];
        if (img[row][col-1][c] > m) m = img[row][col-1][c];
        if (img[row][col][c] > m)   m = img[row][col][c];
        if (RELU && m < 0) m = 0;
        expWe[c]   = 1'b1;
        expData[c] = m;
      end
      if (k == BFRAME - 1) expDone = 1'b1;
      k = (k + 1) % BFRAME;
    end
  endtask

  task automatic checkCycle();
    for (int c = 0; c < BC; c++) begin
      checkOutput($sformatf("we%0d", c), bWe[c], int'(expWe[c]));
      checkOutput($sformatf("data%0d", c), sx4(bWrData[c]), expData[c]);
      if (bWe[c] === 1'b1) wrCount[c]++;
    end
    checkOutput("frameDone", bDone, int'(expDone));
    if (bDone === 1'b1) doneCount++;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] d, input logic nb);
    bRst = r; bValid = v; bData = d; bNextBusy = nb;
    #1;
    checkOutput("busy", bBusy, int'(r | nb));
    @(posedge clk);
    modelStep(r, v, nb, d);
    #1;
    checkCycle();
  endtask

  task automatic checkFrameCounts(input string tag);
    for (int c = 0; c < BC; c++) begin
      checkOutput($sformatf("%s_writes%0d", tag, c), wrCount[c], 4);
      wrCount[c] = 0;
    end
  endtask

  task automatic driveFrame(input bit gaps, input int stallAt, input int resetAt, input bit directed);
    logic [3:0] fr [BFRAME];
    for (int i = 0; i < BFRAME; i++) fr[i] = 4'($urandom_range(15));
    if (directed) begin
      fr[0] = 4'hD; fr[1] = 4'h1; fr[2]  = 4'hF; fr[3]  = 4'h0;
      fr[10] = 4'hE; fr[11] = 4'h0; fr[12] = 4'hC; fr[13] = 4'h0;
    end
    for (int i = 0; i < BFRAME; i++) begin
      if (i == resetAt) begin
        applyStimulus(1'b1, 1'b1, fr[i], 1'b0);
        applyStimulus(1'b1, 1'b1, fr[i], 1'b0);
        for (int c = 0; c < BC; c++) wrCount[c] = 0;
        return;
      end
      if (i == stallAt) begin
        repeat (3) applyStimulus(1'b0, 1'b1, fr[i], 1'b1);
      end
      if (gaps && $urandom_range(2) == 0) applyStimulus(1'b0, 1'b0, 4'($urandom_range(15)), 1'b0);
      applyStimulus(1'b0, 1'b1, fr[i], 1'b0);
      if (directed && i == 12) begin
        checkOutput("s2_we0", bWe[0], 1);
        checkOutput("s2_ch0", sx4(bWrData[0]), RELU ? 0 : -1);
      end
      if (directed && i == 13) begin
        checkOutput("s2_we1", bWe[1], 1);
        checkOutput("s2_we0_off", bWe[0], 0);
        checkOutput("s2_ch1", sx4(bWrData[1]), 1);
      end
    end
  endtask

  initial begin
    $display("[TB] starting pool_layer bench, relu=%0d", RELU);
    for (int c = 0; c < BC; c++) wrCount[c] = 0;
    aExp[0] = 5; aExp[1] = 7;
    aExp[2] = RELU ? 0 : 13;
    aExp[3] = RELU ? 0 : 15;

    bRst = 1'b1; bValid = 1'b0; bData = 4'h0; bNextBusy = 1'b0;
    aRst = 1'b1; aValid = 1'b0; aData = 4'h0; aNextBusy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("a_rst_we", aWe[0], 0);
    checkOutput("a_rst_data", aWrData[0], 0);
    checkOutput("a_rst_done", aDone, 0);
    checkOutput("a_rst_busy", aBusy, 1);
    aRst = 1'b0;

    // Single channel 4x4 ramp 0..15: four windows, done with the last write.
    aIdx = 0;
    for (int s = 0; s < 16; s++) begin
      aValid = 1'b1;
      aData  = s[3:0];
      @(posedge clk);
      #1;
      if (aWe[0] === 1'b1) begin
        if (aIdx < 4) checkOutput($sformatf("a_write%0d", aIdx), aWrData[0], aExp[aIdx]);
        aIdx++;
      end
      checkOutput("a_done", aDone, int'(s == 15));
    end
    aValid = 1'b0;
    checkOutput("a_write_count", aIdx, 4);

    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);

    driveFrame(1'b1, -1, -1, 1'b1);
    checkFrameCounts("f1");
    driveFrame(1'b0, -1, -1, 1'b0);
    checkFrameCounts("f2");
    checkOutput("done_b2b", doneCount, 2);

    driveFrame(1'b1, 20, -1, 1'b0);
    checkFrameCounts("stall");

    driveFrame(1'b0, -1, 7, 1'b0);
    driveFrame(1'b1, -1, -1, 1'b0);
    checkFrameCounts("post_rst");
    checkOutput("done_total", doneCount, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
